// File: rtl/ct_fcnvt_ftoi_seq.sv
// Sequencer for the shared double->int64 shifter: feeds the 1-4 FP64 elements of a packet to the
// shifter one per cycle, rounds, saturates and negates each result, and packs the results with sticky NV/NX flags.
module ct_fcnvt_ftoi_seq #(
  parameter int ELEM_NUM = 4
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    flush,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [1:0]              req_num,
  input  logic [2:0]              req_rm,
  input  logic [64*ELEM_NUM-1:0]  req_src,
  output logic [6:0]              fsh_cnt,
  output logic [52:0]             fsh_src,
  input  logic [63:0]             fsh_i_v_nm,
  input  logic [53:0]             fsh_i_x_nm,
  output logic                    rslt_vld,
  input  logic                    rslt_rdy,
  output logic [64*ELEM_NUM-1:0]  rslt_data,
  output logic                    rslt_nv,
  output logic                    rslt_nx
);
  localparam int          DW      = 64 * ELEM_NUM;
  localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      num_q, num_d;
  logic [2:0]      rm_q, rm_d;
  logic [DW-1:0]   src_q, src_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic            nv_q, nv_d;
  logic            nx_q, nx_d;
  logic            req_rdy_q, req_rdy_d;
  logic            rslt_vld_q, rslt_vld_d;

  logic [63:0]        elem_s;
  logic               sign_s;
  logic [10:0]        exp_s;
  logic [51:0]        man_s;
  logic signed [12:0] unb_exp_s;
  logic               in_rng_s;
  logic               tiny_s;
  logic [63:0]        int_s;
  logic               grd_s;
  logic               stk_s;
  logic               inc_s;
  logic [64:0]        mag_s;
  logic               is_nan_s;
  logic               ovf_exp_s;
  logic               ovf_pos_s;
  logic               ovf_neg_s;
  logic [63:0]        elem_res_s;
  logic               elem_nv_s;
  logic               elem_nx_s;

  // Rounding increment; encodings 5-7 behave as round-toward-zero.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic s, input logic g,
                                   input logic st, input logic lsb);
    logic inc;
    case (rm)
      3'd0:    inc = g & (st | lsb);
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & (g | st);
      3'd3:    inc = ~s & (g | st);
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Element datapath: select lane idx_q, steer the shifter, then round/saturate its output.
  always_comb begin
    elem_s = 64'd0;
    for (int i = 0; i < ELEM_NUM; i++) begin
      elem_s = (idx_q == 2'(i)) ? src_q[64*i +: 64] : elem_s;
    end
    sign_s    = elem_s[63];
    exp_s     = elem_s[62:52];
    man_s     = elem_s[51:0];
    unb_exp_s = $signed({2'b00, exp_s}) - 13'sd1023;
    in_rng_s  = (unb_exp_s >= -13'sd1) && (unb_exp_s <= 13'sd63);
    tiny_s    = (unb_exp_s < -13'sd1);
    fsh_cnt   = in_rng_s ? unb_exp_s[6:0] : 7'd0;
    fsh_src   = {(exp_s != 11'd0), man_s};
    // Below one half the shifter output is meaningless; only "nonzero" matters.
    if (tiny_s) begin
      int_s = 64'd0;
      grd_s = 1'b0;
      stk_s = |elem_s[62:0];
    end else begin
      int_s = fsh_i_v_nm;
      grd_s = fsh_i_x_nm[53];
      stk_s = |fsh_i_x_nm[52:0];
    end
    inc_s     = rnd_inc(rm_q, sign_s, grd_s, stk_s, int_s[0]);
    mag_s     = {1'b0, int_s} + {64'd0, inc_s};
    is_nan_s  = (exp_s == 11'h7FF) && (man_s != 52'd0);
    ovf_exp_s = (exp_s == 11'h7FF) || (unb_exp_s >= 13'sd64);
    ovf_pos_s = ~sign_s & (mag_s[64] | mag_s[63]);
    ovf_neg_s = sign_s & (mag_s[64] | (mag_s[63] & (|mag_s[62:0])));
    if (is_nan_s) begin
      elem_res_s = INT_MAX;
      elem_nv_s  = 1'b1;
    end else if (ovf_exp_s) begin
      elem_res_s = sign_s ? INT_MIN : INT_MAX;
      elem_nv_s  = 1'b1;
    end else if (ovf_pos_s) begin
      elem_res_s = INT_MAX;
      elem_nv_s  = 1'b1;
    end else if (ovf_neg_s) begin
      elem_res_s = INT_MIN;
      elem_nv_s  = 1'b1;
    end else begin
      elem_res_s = sign_s ? (64'd0 - mag_s[63:0]) : mag_s[63:0];
      elem_nv_s  = 1'b0;
    end
    elem_nx_s = ~elem_nv_s & (grd_s | stk_s);
  end

  // Next-state and packet bookkeeping; flush wins over everything else.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rm_d    = rm_q;
    src_d   = src_q;
    idx_d   = idx_q;
    data_d  = data_q;
    nv_d    = nv_q;
    nx_d    = nx_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (req_vld) begin
          state_d = ST_BUSY;
          num_d   = req_num;
          rm_d    = req_rm;
          src_d   = req_src;
          idx_d   = 2'd0;
          data_d  = {DW{1'b0}};
          nv_d    = 1'b0;
          nx_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end else begin
          for (int i = 0; i < ELEM_NUM; i++) begin
            data_d[64*i +: 64] = (idx_q == 2'(i)) ? elem_res_s : data_q[64*i +: 64];
          end
          nv_d = nv_q | elem_nv_s;
          nx_d = nx_q | elem_nx_s;
          if (idx_q == num_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (flush || rslt_rdy) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
    req_rdy_d  = (state_d == ST_IDLE);
    rslt_vld_d = (state_d == ST_DONE);
  end

  // State, packet and handshake registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_IDLE;
      num_q      <= 2'd0;
      rm_q       <= 3'd0;
      src_q      <= {DW{1'b0}};
      idx_q      <= 2'd0;
      data_q     <= {DW{1'b0}};
      nv_q       <= 1'b0;
      nx_q       <= 1'b0;
      req_rdy_q  <= 1'b1;
      rslt_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      rm_q       <= rm_d;
      src_q      <= src_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      nv_q       <= nv_d;
      nx_q       <= nx_d;
      req_rdy_q  <= req_rdy_d;
      rslt_vld_q <= rslt_vld_d;
    end
  end

  assign req_rdy   = req_rdy_q;
  assign rslt_vld  = rslt_vld_q;
  assign rslt_data = data_q;
  assign rslt_nv   = nv_q;
  assign rslt_nx   = nx_q;

endmodule

// File: tb/tb_ct_fcnvt_ftoi_seq.sv
// Bench for ct_fcnvt_ftoi_seq: directed packets plus random packets checked against an
// exact-remainder conversion model; a stand-in shifter closes the loop.
module tb_ct_fcnvt_ftoi_seq;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic         forever_cpuclk = 1'b0;
  logic         cpurst_b;
  logic         flush;
  logic         req_vld;
  logic         req_rdy;
  logic [1:0]   req_num;
  logic [2:0]   req_rm;
  logic [255:0] req_src;
  logic [6:0]   fsh_cnt;
  logic [52:0]  fsh_src;
  logic [63:0]  fsh_i_v_nm;
  logic [53:0]  fsh_i_x_nm;
  logic         rslt_vld;
  logic         rslt_rdy;
  logic [255:0] rslt_data;
  logic         rslt_nv;
  logic         rslt_nx;

  int nvec = 0;
  int nerr = 0;

  logic [127:0] shw;
  int           shn;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_fcnvt_ftoi_seq dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .flush          (flush),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_num        (req_num),
    .req_rm         (req_rm),
    .req_src        (req_src),
    .fsh_cnt        (fsh_cnt),
    .fsh_src        (fsh_src),
    .fsh_i_v_nm     (fsh_i_v_nm),
    .fsh_i_x_nm     (fsh_i_x_nm),
    .rslt_vld       (rslt_vld),
    .rslt_rdy       (rslt_rdy),
    .rslt_data      (rslt_data),
    .rslt_nv        (rslt_nv),
    .rslt_nx        (rslt_nx)
  );

  // Stand-in for the combinational shifter: value = src * 2^(cnt-52), cnt signed 7-bit.
  always_comb begin
    shn = int'($signed(fsh_cnt)) + 1;
    if (shn < 0) shn = 0;
    shw = {75'd0, fsh_src} << shn;
    fsh_i_v_nm = shw[116:53];
    fsh_i_x_nm = {shw[52:0], 1'b0};
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Conversion model: exact integer part and remainder compared against one half.
  function automatic void ref_cvt(input logic [63:0] x, input logic [2:0] rm,
                                  output logic [63:0] r, output logic nv, output logic nx);
    logic s;
    int E, sh, cmp, mode;
    logic [127:0] M, ip, rem, half, mag;
    logic up;
    s = x[63];
    E = int'(x[62:52]) - 1023;
    M = {75'd0, (x[62:52] != 11'd0), x[51:0]};
    r = 64'd0; nv = 1'b0; nx = 1'b0;
    if (x[62:52] == 11'h7FF && x[51:0] != 52'd0) begin
      nv = 1'b1; r = MAXV;
    end else if (x[62:52] == 11'h7FF || E >= 64) begin
      nv = 1'b1; r = s ? MINV : MAXV;
    end else begin
      if (E >= 52) begin
        ip = M << (E - 52); cmp = 0;
      end else if (E >= -60) begin
        sh   = 52 - E;
        ip   = M >> sh;
        rem  = M - (ip << sh);
        half = 128'd1 << (sh - 1);
        cmp  = (rem == 0) ? 0 : (rem < half) ? 1 : (rem == half) ? 2 : 3;
      end else begin
        ip = 128'd0; cmp = (M == 0) ? 0 : 1;
      end
      mode = (rm > 3'd4) ? 1 : int'(rm);
      case (mode)
        0: up = (cmp == 3) || (cmp == 2 && ip[0]);
        2: up = s && cmp != 0;
        3: up = !s && cmp != 0;
        4: up = cmp >= 2;
        default: up = 1'b0;
      endcase
      mag = ip + {127'd0, up};
      if (!s && mag >= (128'd1 << 63)) begin
        nv = 1'b1; r = MAXV;
      end else if (s && mag > (128'd1 << 63)) begin
        nv = 1'b1; r = MINV;
      end else begin
        r  = s ? (64'd0 - mag[63:0]) : mag[63:0];
        nx = (cmp != 0);
      end
    end
  endfunction

  function automatic logic [63:0] gen_elem();
    logic [63:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: x[62:0] = 63'd0;
      1: begin
        x[62:52] = 11'h7FF;
        if ($urandom_range(0, 1) == 1) x[51:0] = 52'd0;
      end
      2: x[62:52] = 11'd0;
      3: begin
        x[62:52] = 11'(1085 + $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) x[51:0] = 52'd0;
      end
      default: begin
        x[62:52] = 11'(957 + $urandom_range(0, 133));
        if ($urandom_range(0, 2) == 0) x[30:0] = 31'd0;
      end
    endcase
    return x;
  endfunction

  task automatic run_pkt(input logic [1:0] num, input logic [2:0] rm, input logic [255:0] src,
                         input int hold, output logic [255:0] od, output logic onv, output logic onx);
    logic [255:0] ed;
    logic [63:0]  lv;
    logic         env, enx, ln, lx;
    int           cnt;
    ed = 256'd0; env = 1'b0; enx = 1'b0;
    for (int i = 0; i <= int'(num); i++) begin
      ref_cvt(src[64*i +: 64], rm, lv, ln, lx);
      ed[64*i +: 64] = lv;
      env |= ln;
      enx |= lx;
    end
    chk("req_rdy_idle", {255'd0, req_rdy}, 256'd1);
    req_vld = 1'b1; req_num = num; req_rm = rm; req_src = src;
    @(negedge forever_cpuclk);
    req_vld = 1'b0; req_src = {8{$urandom}};
    cnt = 0;
    while (!rslt_vld && cnt < 10) begin
      chk("req_rdy_busy", {255'd0, req_rdy}, 256'd0);
      @(negedge forever_cpuclk);
      cnt++;
    end
    chk("latency", 256'(cnt), 256'(int'(num) + 1));
    chk("data", rslt_data, ed);
    chk("nv", {255'd0, rslt_nv}, {255'd0, env});
    chk("nx", {255'd0, rslt_nx}, {255'd0, enx});
    od = rslt_data; onv = rslt_nv; onx = rslt_nx;
    for (int h = 0; h < hold; h++) begin
      @(negedge forever_cpuclk);
      chk("hold_data", rslt_data, ed);
      chk("hold_vld_rdy", {254'd0, rslt_vld, req_rdy}, {254'd0, 2'b10});
    end
    rslt_rdy = 1'b1;
    @(negedge forever_cpuclk);
    rslt_rdy = 1'b0;
    chk("release", {254'd0, rslt_vld, req_rdy}, {254'd0, 2'b01});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] od;
    logic         onv, onx;
    int           cnt;
    logic         seen;
    cpurst_b = 1'b0; flush = 1'b0; req_vld = 1'b0; rslt_rdy = 1'b0;
    req_num = 2'd0; req_rm = 3'd0; req_src = 256'd0;
    repeat (2) @(negedge forever_cpuclk);
    chk("reset_state", {rslt_data, rslt_vld, req_rdy, rslt_nv, rslt_nx} >> 4, 256'd0);
    chk("reset_hs", {252'd0, rslt_vld, req_rdy, rslt_nv, rslt_nx}, {252'd0, 4'b0100});
    cpurst_b = 1'b1;
    @(negedge forever_cpuclk);

    // T1
    run_pkt(2'd0, 3'd0, {192'd0, 64'h3FF8000000000000}, 1, od, onv, onx);
    chk("t1", {od, onv, onx}, {192'd0, 64'd2, 2'b01});
    // T2
    run_pkt(2'd1, 3'd0, {128'd0, 64'hBFE0000000000000, 64'h4004000000000000}, 0, od, onv, onx);
    chk("t2_rne", {od, onv, onx}, {128'd0, 64'd0, 64'd2, 2'b01});
    run_pkt(2'd1, 3'd2, {128'd0, 64'hBFE0000000000000, 64'h4004000000000000}, 0, od, onv, onx);
    chk("t2_rdn", {od, onv, onx}, {128'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b01});
    // T3
    run_pkt(2'd2, 3'd1, {64'd0, 64'h7FF8000000000000, 64'hC3E0000000000000, 64'h43E0000000000000},
            0, od, onv, onx);
    chk("t3", {od, onv}, {64'd0, MAXV, MINV, MAXV, 1'b1});
    run_pkt(2'd0, 3'd1, {192'd0, 64'hC3E0000000000000}, 0, od, onv, onx);
    chk("t3_lane1", {od, onv, onx}, {192'd0, MINV, 2'b00});
    // T4
    run_pkt(2'd3, 3'd4, {gen_elem(), gen_elem(), gen_elem(), gen_elem()}, 10, od, onv, onx);

    // T5: flush during the second BUSY cycle
    req_vld = 1'b1; req_num = 2'd3; req_rm = 3'd0; req_src = {4{64'h3FF8000000000000}};
    @(negedge forever_cpuclk);
    req_vld = 1'b0;
    @(negedge forever_cpuclk);
    flush = 1'b1;
    @(negedge forever_cpuclk);
    flush = 1'b0;
    chk("t5_flush", {254'd0, rslt_vld, req_rdy}, {254'd0, 2'b01});
    seen = 1'b0;
    repeat (6) begin
      @(negedge forever_cpuclk);
      seen |= rslt_vld;
    end
    chk("t5_no_vld", {255'd0, seen}, 256'd0);
    run_pkt(2'd1, 3'd0, {128'd0, 64'hBFE0000000000000, 64'h4004000000000000}, 0, od, onv, onx);
    chk("t5_next", {od, onv, onx}, {128'd0, 64'd0, 64'd2, 2'b01});

    // T6: reset while DONE
    req_vld = 1'b1; req_num = 2'd1; req_rm = 3'd0; req_src = {4{64'h43E0000000000000}};
    @(negedge forever_cpuclk);
    req_vld = 1'b0;
    cnt = 0;
    while (!rslt_vld && cnt < 10) begin
      @(negedge forever_cpuclk);
      cnt++;
    end
    chk("t6_done", {255'd0, rslt_vld}, 256'd1);
    cpurst_b = 1'b0;
    #1;
    chk("t6_rst", {252'd0, rslt_vld, req_rdy, rslt_nv, rslt_nx}, {252'd0, 4'b0100});
    chk("t6_rst_data", rslt_data, 256'd0);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    @(negedge forever_cpuclk);
    run_pkt(2'd0, 3'd3, {192'd0, 64'h3FEFFFFFFFFFFFFF}, 0, od, onv, onx);
    chk("t6_rup", {od, onv, onx}, {192'd0, 64'd1, 2'b01});

    // Random packets against the model
    for (int k = 0; k < 60; k++) begin
      run_pkt(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              {gen_elem(), gen_elem(), gen_elem(), gen_elem()},
              $urandom_range(0, 2), od, onv, onx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
